// File: rtl/iq_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
package iq_pkg;

  localparam int IQ_DEPTH          = 8;
  localparam int IQ_DISPATCH_WIDTH = 2;
  localparam int IQ_WAKEUP_WIDTH   = 2;
  localparam int IQ_SRC_NUM        = 2;
  localparam int IQ_PREG_W         = 6;
  localparam int IQ_PAYLOAD_W      = 32;

  typedef struct packed {
    logic                                 valid;
    logic [IQ_SRC_NUM-1:0][IQ_PREG_W-1:0] psrc;
    logic [IQ_SRC_NUM-1:0]                src_rdy;
    logic [IQ_PREG_W-1:0]                 pdst;
    logic [IQ_PAYLOAD_W-1:0]              payload;
  } iq_entry_t;

  function automatic logic [IQ_DEPTH-1:0] onehot_lowest(input logic [IQ_DEPTH-1:0] v);
    onehot_lowest = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        onehot_lowest    = '0;
        onehot_lowest[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker: older[i][j]=1 means slot i was allocated before slot j.
// Lanes allocated in one cycle are ordered lane 0 oldest; all are younger than residents.
module iq_age_matrix #(
  parameter int DEPTH = 8,
  parameter int LANES = 2
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic [LANES-1:0][DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0]            req_i,
  output logic [DEPTH-1:0]            oldest_o
);

  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [LANES-1:0][DEPTH-1:0] younger_than_lane;
  logic [DEPTH-1:0][DEPTH-1:0] row_val;
  logic [DEPTH-1:0]            is_alloc;

  always_comb begin
    younger_than_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int m = k + 1; m < LANES; m++) begin
        younger_than_lane[k] = younger_than_lane[k] | alloc_i[m];
      end
    end
  end

  // A new slot's row marks only later lanes of the same group as younger.
  always_comb begin
    is_alloc = '0;
    row_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < LANES; k++) begin
        if (alloc_i[k][i]) begin
          is_alloc[i] = 1'b1;
          row_val[i]  = younger_than_lane[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i != j) begin
            if (is_alloc[i]) begin
              older[i][j] <= row_val[i][j];
            end else if (is_alloc[j]) begin
              older[i][j] <= ~row_val[j][i];
            end
          end
        end
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && older[j][i]) blocked = 1'b1;
      end
      oldest_o[i] = req_i[i] && !blocked;
    end
  end

endmodule

// File: rtl/issue_queue_ooo.sv
// Out-of-order issue queue: multi-lane dispatch, tag wakeup with dispatch bypass,
// oldest-ready select over valid/ready, and flush.
module issue_queue_ooo
  import iq_pkg::*;
#(
  parameter int DEPTH          = IQ_DEPTH,
  parameter int DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
  parameter int WAKEUP_WIDTH   = IQ_WAKEUP_WIDTH,
  parameter int SRC_NUM        = IQ_SRC_NUM,
  parameter int PREG_W         = IQ_PREG_W,
  parameter int PAYLOAD_W      = IQ_PAYLOAD_W
) (
  input  logic                                 clk,
  input  logic                                 a_rst_n,
  input  logic                                 flush_i,
  input  logic [DISPATCH_WIDTH-1:0]            disp_valid_i,
  output logic                                 disp_ready_o,
  input  logic [DISPATCH_WIDTH*SRC_NUM*PREG_W-1:0] disp_psrc_i,
  input  logic [DISPATCH_WIDTH*SRC_NUM-1:0]    disp_src_rdy_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]     disp_pdst_i,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]  disp_payload_i,
  input  logic [WAKEUP_WIDTH-1:0]              wakeup_valid_i,
  input  logic [WAKEUP_WIDTH*PREG_W-1:0]       wakeup_preg_i,
  output logic                                 issue_valid_o,
  input  logic                                 issue_ready_i,
  output logic [PREG_W-1:0]                    issue_pdst_o,
  output logic [PAYLOAD_W-1:0]                 issue_payload_o,
  output logic [$clog2(DEPTH):0]               occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  iq_entry_t                             q [DEPTH];
  iq_entry_t                             new_ent [DISPATCH_WIDTH];
  logic [OCC_W-1:0]                      occ;
  logic [OCC_W-1:0]                      n_disp;
  logic [DEPTH-1:0]                      valid_vec;
  logic [DEPTH-1:0]                      free_mask;
  logic [DEPTH-1:0]                      eligible;
  logic [DEPTH-1:0]                      grant;
  logic [DEPTH-1:0][SRC_NUM-1:0]         wake_hit;
  logic [DISPATCH_WIDTH-1:0][DEPTH-1:0]  alloc_oh;
  logic                                  issue_fire;

  function automatic logic tag_match(
    input logic [PREG_W-1:0]              tag,
    input logic [WAKEUP_WIDTH-1:0]        vld,
    input logic [WAKEUP_WIDTH*PREG_W-1:0] tags
  );
    tag_match = 1'b0;
    for (int w = 0; w < WAKEUP_WIDTH; w++) begin
      if (vld[w] && tags[w*PREG_W +: PREG_W] == tag) tag_match = 1'b1;
    end
  endfunction

  assign occupancy_o  = occ;
  // Registered count only: a slot freed by this cycle's issue cannot be reused yet.
  assign disp_ready_o = ((OCC_W'(DEPTH) - occ) >= OCC_W'(DISPATCH_WIDTH)) && !flush_i;

  always_comb begin
    valid_vec = '0;
    eligible  = '0;
    wake_hit  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = q[i].valid;
      eligible[i]  = q[i].valid && (&q[i].src_rdy);
      for (int s = 0; s < SRC_NUM; s++) begin
        wake_hit[i][s] = tag_match(q[i].psrc[s], wakeup_valid_i, wakeup_preg_i);
      end
    end
  end

  always_comb begin
    free_mask = ~valid_vec;
    alloc_oh  = '0;
    n_disp    = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (disp_valid_i[k] && disp_ready_o) begin
        alloc_oh[k] = onehot_lowest(free_mask);
        free_mask   = free_mask & ~alloc_oh[k];
        n_disp      = n_disp + OCC_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      new_ent[k]         = '0;
      new_ent[k].valid   = 1'b1;
      new_ent[k].pdst    = disp_pdst_i[k*PREG_W +: PREG_W];
      new_ent[k].payload = disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
      for (int s = 0; s < SRC_NUM; s++) begin
        new_ent[k].psrc[s]    = disp_psrc_i[(k*SRC_NUM+s)*PREG_W +: PREG_W];
        new_ent[k].src_rdy[s] = disp_src_rdy_i[k*SRC_NUM+s] ||
                                tag_match(new_ent[k].psrc[s], wakeup_valid_i, wakeup_preg_i);
      end
    end
  end

  iq_age_matrix #(
    .DEPTH (DEPTH),
    .LANES (DISPATCH_WIDTH)
  ) u_age (
    .clk      (clk),
    .a_rst_n  (a_rst_n),
    .alloc_i  (alloc_oh),
    .req_i    (eligible),
    .oldest_o (grant)
  );

  assign issue_valid_o = (|eligible) && !flush_i;
  assign issue_fire    = issue_valid_o && issue_ready_i;

  always_comb begin
    issue_pdst_o    = '0;
    issue_payload_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_pdst_o    = issue_pdst_o | q[i].pdst;
        issue_payload_o = issue_payload_o | q[i].payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else if (flush_i) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      occ <= occ + n_disp - OCC_W'(issue_fire);
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid) begin
          for (int s = 0; s < SRC_NUM; s++) begin
            if (wake_hit[i][s]) q[i].src_rdy[s] <= 1'b1;
          end
        end
        if (issue_fire && grant[i]) q[i].valid <= 1'b0;
        // Allocated slots are never valid, so these writes never collide with the above.
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (alloc_oh[k][i]) q[i] <= new_ent[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo with an age-ordered queue reference model.
module tb_issue_queue_ooo;

  logic        clk = 1'b0;
  logic        a_rst_n;
  logic        flush;
  logic [1:0]  disp_valid;
  logic        disp_ready;
  logic [23:0] disp_psrc;
  logic [3:0]  disp_src_rdy;
  logic [11:0] disp_pdst;
  logic [63:0] disp_payload;
  logic [1:0]  wakeup_valid;
  logic [11:0] wakeup_preg;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_pdst;
  logic [31:0] issue_payload;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  typedef struct {
    logic [5:0]  s0, s1;
    bit          r0, r1;
    logic [5:0]  pdst;
    logic [31:0] pay;
  } ment_t;

  ment_t mq[$];

  always #5 clk = ~clk;

  issue_queue_ooo dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .flush_i         (flush),
    .disp_valid_i    (disp_valid),
    .disp_ready_o    (disp_ready),
    .disp_psrc_i     (disp_psrc),
    .disp_src_rdy_i  (disp_src_rdy),
    .disp_pdst_i     (disp_pdst),
    .disp_payload_i  (disp_payload),
    .wakeup_valid_i  (wakeup_valid),
    .wakeup_preg_i   (wakeup_preg),
    .issue_valid_o   (issue_valid),
    .issue_ready_i   (issue_ready),
    .issue_pdst_o    (issue_pdst),
    .issue_payload_o (issue_payload),
    .occupancy_o     (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit w_hit(input logic [5:0] tag);
    for (int w = 0; w < 2; w++) begin
      if (wakeup_valid[w] && wakeup_preg[w*6 +: 6] == tag) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Oldest entry with both operands ready, by position in the age-ordered queue.
  function automatic int m_winner();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r0 && mq[i].r1) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!a_rst_n || flush) begin
      mq.delete();
    end else begin
      int    w;
      int    room;
      ment_t e;
      room = 8 - mq.size();
      w    = m_winner();
      if (w >= 0 && issue_ready) mq.delete(w);
      for (int i = 0; i < mq.size(); i++) begin
        if (w_hit(mq[i].s0)) mq[i].r0 = 1'b1;
        if (w_hit(mq[i].s1)) mq[i].r1 = 1'b1;
      end
      if (room >= 2) begin
        for (int k = 0; k < 2; k++) begin
          if (disp_valid[k]) begin
            e.s0   = disp_psrc[(k*2)*6 +: 6];
            e.s1   = disp_psrc[(k*2+1)*6 +: 6];
            e.r0   = disp_src_rdy[k*2] || w_hit(e.s0);
            e.r1   = disp_src_rdy[k*2+1] || w_hit(e.s1);
            e.pdst = disp_pdst[k*6 +: 6];
            e.pay  = disp_payload[k*32 +: 32];
            mq.push_back(e);
          end
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      int w;
      w = m_winner();
      chk("m_disp_ready", disp_ready, ((8 - mq.size()) >= 2) && !flush);
      chk("m_issue_valid", issue_valid, (w >= 0) && !flush);
      chk("m_occupancy", occupancy, mq.size());
      if (w >= 0 && !flush) begin
        chk("m_issue_pdst", issue_pdst, mq[w].pdst);
        chk("m_issue_payload", issue_payload, mq[w].pay);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    flush        = 1'b0;
    disp_valid   = '0;
    disp_psrc    = '0;
    disp_src_rdy = '0;
    disp_pdst    = '0;
    disp_payload = '0;
    wakeup_valid = '0;
    wakeup_preg  = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lane(input int k, input logic [5:0] s0, input bit r0, input logic [5:0] s1,
                      input bit r1, input logic [5:0] pdst, input logic [31:0] pay);
    disp_valid[k]               = 1'b1;
    disp_psrc[(k*2)*6 +: 6]     = s0;
    disp_psrc[(k*2+1)*6 +: 6]   = s1;
    disp_src_rdy[k*2]           = r0;
    disp_src_rdy[k*2+1]         = r1;
    disp_pdst[k*6 +: 6]         = pdst;
    disp_payload[k*32 +: 32]    = pay;
  endtask

  task automatic wake(input int w, input logic [5:0] tag);
    wakeup_valid[w]      = 1'b1;
    wakeup_preg[w*6 +: 6] = tag;
  endtask

  initial begin
    a_rst_n     = 1'b0;
    issue_ready = 1'b0;
    tick();
    repeat (3) tick();
    a_rst_n = 1'b1;
    chk_en  = 1'b1;
    settle();
    chk("rst_occ", occupancy, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);

    // Two ready ops: lane 0 first, occupancy 0->2->1->0.
    tick(); issue_ready = 1'b1;
    lane(0, 6'd1, 1, 6'd2, 1, 6'd10, 32'hA0);
    lane(1, 6'd3, 1, 6'd4, 1, 6'd11, 32'hA1);
    tick(); settle();
    chk("t1_occ2", occupancy, 2);
    chk("t1_valid", issue_valid, 1);
    chk("t1_pdst_lane0", issue_pdst, 10);
    chk("t1_payload_lane0", issue_payload, 32'hA0);
    tick(); settle();
    chk("t1_occ1", occupancy, 1);
    chk("t1_pdst_lane1", issue_pdst, 11);
    tick(); settle();
    chk("t1_occ0", occupancy, 0);
    chk("t1_empty", issue_valid, 0);

    // Fill with ops waiting on tag 5, then wake them.
    for (int p = 0; p < 4; p++) begin
      tick();
      lane(0, 6'd5, 0, 6'd5, 0, 6'(20 + 2*p), 32'(32'h200 + 2*p));
      lane(1, 6'd5, 0, 6'd5, 0, 6'(21 + 2*p), 32'(32'h201 + 2*p));
      settle();
      if (p == 3) chk("t2_ready_at6", disp_ready, 1);
    end
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd63, 32'hDEAD);
    lane(1, 6'd1, 1, 6'd1, 1, 6'd62, 32'hBEEF);
    settle();
    chk("t2_occ8", occupancy, 8);
    chk("t2_full_ready", disp_ready, 0);
    chk("t2_not_ready_ops", issue_valid, 0);
    tick(); wake(0, 6'd5); settle();
    chk("t2_wake_same_cycle", issue_valid, 0);
    tick(); settle();
    chk("t2_woken", issue_valid, 1);
    chk("t2_oldest", issue_pdst, 20);
    tick(); settle();
    chk("t2_occ7", occupancy, 7);
    chk("t2_ready_at7", disp_ready, 0);
    chk("t2_second", issue_pdst, 21);
    repeat (7) tick();
    settle();
    chk("t2_drained", occupancy, 0);

    // Dispatch-cycle wakeup bypass.
    tick();
    lane(0, 6'd9, 0, 6'd1, 1, 6'd30, 32'h300);
    wake(1, 6'd9);
    tick(); settle();
    chk("t3_bypass_valid", issue_valid, 1);
    chk("t3_bypass_pdst", issue_pdst, 30);
    tick();

    // Younger op wakes first; older one takes over once eligible.
    issue_ready = 1'b0;
    tick();
    lane(0, 6'd13, 0, 6'd13, 0, 6'd40, 32'h400);
    lane(1, 6'd14, 0, 6'd14, 0, 6'd41, 32'h401);
    tick(); wake(0, 6'd14); settle();
    chk("t4_none", issue_valid, 0);
    tick(); wake(1, 6'd13); settle();
    chk("t4_younger", issue_pdst, 41);
    tick(); settle();
    chk("t4_older_takes", issue_pdst, 40);
    tick(); issue_ready = 1'b1; settle();
    chk("t4_older_issue", issue_pdst, 40);
    tick(); settle();
    chk("t4_then_younger", issue_pdst, 41);
    tick(); settle();
    chk("t4_empty", issue_valid, 0);

    // Occupancy 6 with simultaneous issue and dispatch.
    issue_ready = 1'b0;
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd50, 32'h500);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd51, 32'h501);
    tick();
    lane(0, 6'd15, 0, 6'd15, 0, 6'd52, 32'h502);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd53, 32'h503);
    tick();
    lane(0, 6'd15, 0, 6'd15, 0, 6'd54, 32'h504);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd55, 32'h505);
    tick(); issue_ready = 1'b1;
    lane(0, 6'd15, 0, 6'd15, 0, 6'd56, 32'h506);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd57, 32'h507);
    settle();
    chk("t5_occ6", occupancy, 6);
    chk("t5_ready6", disp_ready, 1);
    chk("t5_issue50", issue_pdst, 50);
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd58, 32'h508);
    lane(1, 6'd1, 1, 6'd1, 1, 6'd59, 32'h509);
    settle();
    chk("t5_occ7", occupancy, 7);
    chk("t5_no_reuse", disp_ready, 0);
    tick(); flush = 1'b1;
    lane(0, 6'd1, 1, 6'd1, 1, 6'd58, 32'h508);
    settle();
    chk("t5_flush_ready", disp_ready, 0);
    tick(); settle();
    chk("t5_flushed_occ", occupancy, 0);

    // Flush with five resident entries, one eligible, and a dispatch pending.
    issue_ready = 1'b0;
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd60, 32'h600);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd61, 32'h601);
    tick();
    lane(0, 6'd15, 0, 6'd15, 0, 6'd62, 32'h602);
    lane(1, 6'd15, 0, 6'd15, 0, 6'd63, 32'h603);
    tick();
    lane(1, 6'd15, 0, 6'd15, 0, 6'd1, 32'h604);
    tick(); flush = 1'b1; issue_ready = 1'b1;
    lane(0, 6'd1, 1, 6'd1, 1, 6'd2, 32'h605);
    lane(1, 6'd1, 1, 6'd1, 1, 6'd3, 32'h606);
    settle();
    chk("t6_occ5", occupancy, 5);
    chk("t6_flush_no_issue", issue_valid, 0);
    chk("t6_flush_no_disp", disp_ready, 0);
    tick(); settle();
    chk("t6_occ0", occupancy, 0);
    chk("t6_no_issue", issue_valid, 0);
    chk("t6_ready", disp_ready, 1);
    tick(); wake(0, 6'd15);
    tick(); settle();
    chk("t6_gone", issue_valid, 0);
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd4, 32'h607);
    tick(); settle();
    chk("t6_after_flush", issue_pdst, 4);

    // Reset in the middle of operation.
    issue_ready = 1'b0;
    tick();
    lane(0, 6'd1, 1, 6'd1, 1, 6'd5, 32'h700);
    lane(1, 6'd1, 1, 6'd1, 1, 6'd6, 32'h701);
    tick(); a_rst_n = 1'b0;
    tick(); a_rst_n = 1'b1; settle();
    chk("t7_rst_occ", occupancy, 0);
    chk("t7_rst_valid", issue_valid, 0);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
